// File: rtl/async_fifo_wr_arb.sv
// Packet-level round-robin arbiter sharing one dual-clock FIFO write port between NUM_REQ requesters.
// Optional macro ASYNC_FIFO_ARB_TAG_EN widens fifo_data_o to {gnt_idx, beat} so the read side can demultiplex.

module async_fifo_wr_arb_chk #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                          wr_clk,
  input logic                          wr_rst_n,
  input logic [NUM_REQ-1:0]            req_valid_i,
  input logic [NUM_REQ-1:0]            req_ready_o,
  input logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i
);
  logic [NUM_REQ-1:0]            pend_r;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_r;

  // Remember which requesters were left waiting at the previous edge
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      pend_r <= '0;
      data_r <= '0;
    end else begin
      pend_r <= req_valid_i & ~req_ready_o;
      data_r <= req_data_i;
    end
  end

  // A waiting requester must hold valid and its beat until it is accepted
  always @(posedge wr_clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr_rst_n && pend_r[k]) begin
        assert (req_valid_i[k]);
        assert (req_data_i[k*DATA_WIDTH +: DATA_WIDTH] == data_r[k*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end
endmodule

module async_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_WIDTH = $clog2(NUM_REQ),
`ifdef ASYNC_FIFO_ARB_TAG_EN
  localparam int FIFO_WIDTH = DATA_WIDTH + IDX_WIDTH
`else
  localparam int FIFO_WIDTH = DATA_WIDTH
`endif
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic                          fifo_valid_o,
  input  logic                          fifo_ready_i,
  output logic [FIFO_WIDTH-1:0]         fifo_data_o,
  input  logic                          fifo_almost_full_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t                state_r, state_s;
  logic [IDX_WIDTH-1:0]  gnt_idx_r, rr_ptr_r, pick_idx_s, next_ptr_s;
  logic                  pick_found_s, cur_valid_s, cur_last_s;
  logic                  start_s, accept_s, done_s;
  logic [DATA_WIDTH-1:0] cur_data_s;
  logic [NUM_REQ-1:0]    grant_r;
  logic                  busy_r;
  logic [CNT_WIDTH-1:0]  pkt_cnt_r;

  function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return IDX_WIDTH'(sum);
  endfunction

  // First valid requester searching upward from the round-robin pointer
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found_s && req_valid_i[wrap_add(rr_ptr_r, i)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = wrap_add(rr_ptr_r, i);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Select the granted requester's valid, last and beat
  always_comb begin
    cur_valid_s = 1'b0;
    cur_last_s  = 1'b0;
    cur_data_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx_r == IDX_WIDTH'(k)) begin
        cur_valid_s = req_valid_i[k];
        cur_last_s  = req_last_i[k];
        cur_data_s  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        cur_valid_s = cur_valid_s;
      end
    end
  end

  assign start_s    = (state_r == ST_IDLE) && pick_found_s && !fifo_almost_full_i;
  assign accept_s   = (state_r == ST_BURST) && cur_valid_s && fifo_ready_i;
  assign done_s     = accept_s && cur_last_s;
  assign next_ptr_s = wrap_add(gnt_idx_r, 1);

  // State register
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; almost-full only gates the start of a packet
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_BURST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BURST;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Grant, pointer and packet counter registers
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      gnt_idx_r <= '0;
      rr_ptr_r  <= '0;
      grant_r   <= '0;
      busy_r    <= 1'b0;
      pkt_cnt_r <= '0;
    end else if (start_s) begin
      gnt_idx_r <= pick_idx_s;
      grant_r   <= NUM_REQ'(1) << pick_idx_s;
      busy_r    <= 1'b1;
    end else if (done_s) begin
      rr_ptr_r  <= next_ptr_s;
      pkt_cnt_r <= pkt_cnt_r + CNT_WIDTH'(1);
      grant_r   <= '0;
      busy_r    <= 1'b0;
    end
  end

  // Pass-through of the granted requester while a packet is in flight
  always_comb begin
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    req_ready_o  = '0;
    if (state_r == ST_BURST) begin
      fifo_valid_o           = cur_valid_s;
`ifdef ASYNC_FIFO_ARB_TAG_EN
      fifo_data_o            = {gnt_idx_r, cur_data_s};
`else
      fifo_data_o            = cur_data_s;
`endif
      req_ready_o[gnt_idx_r] = fifo_ready_i;
    end else begin
      fifo_valid_o = 1'b0;
    end
  end

  assign grant_o   = grant_r;
  assign busy_o    = busy_r;
  assign pkt_cnt_o = pkt_cnt_r;

  async_fifo_wr_arb_chk #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i)
  );
endmodule
